subtree_rr_scheduler: RTL and testbench
=======================================

Name: subtree_rr_scheduler

Overview:
- Round-robin scheduler granting exclusive access to one shared resource among the sibling child instances of a generated hierarchy node (10 children per node).
- Placed once per node, next to the child instances.
- Children raise a level request, hold it for as long as they need the resource, then drop it.
- Registered one-hot grant, a forced turnaround gap between owners, and fair rotation of priority.

Parameters:
- NUM_REQ, 10, number of requesters (2..16).
- TURN_CYCLES, 1, idle cycles after a release before the next grant may issue (1..15).
- MAX_HOLD, 64, maximum grant length in cycles; used only with SUBTREE_SCHED_TIMEOUT_EN.
- HOLD_W, 8, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arb_en  in  1  when 0, no new grant issues; an existing grant continues.
- req  in  NUM_REQ  level requests, bit i = child i.
- gnt  out  NUM_REQ  registered one-hot grant; all zero when no owner.
- gnt_valid  out  1  OR of gnt.
- gnt_id  out  IDW  index of the owner, IDW = $clog2(NUM_REQ); holds its last value when gnt_valid=0.
- hold_cnt  out  HOLD_W  cycles the current owner has held the grant; saturates at all-ones.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, timeout=0.
  - Priority pointer ptr=0; state IDLE; gap counter=0.
  - Reset asserted mid-grant clears all of the above immediately, without waiting for a clock.
- States: IDLE, GRANT, GAP.
- IDLE:
  - At a clock edge where arb_en=1 and req!=0, select the first set bit scanning ptr, ptr+1, ... with wrap NUM_REQ-1 -> 0.
  - After that edge: gnt bit set, gnt_id=index, hold_cnt=1, state GRANT. Latency from req sampled to gnt is 1 cycle.
  - With arb_en=0 or req=0: stay in IDLE, outputs unchanged.
- GRANT:
  - While req[gnt_id]=1: hold the grant; hold_cnt increments each cycle and saturates.
  - Requests from non-owners are ignored and not latched; they are level-held by the requester.
  - Edge where req[gnt_id]=0: gnt cleared after that edge, hold_cnt=0, ptr=(gnt_id+1) mod NUM_REQ, gap counter=TURN_CYCLES, state GAP.
- GAP:
  - No grant. The gap counter decrements each edge; when it reaches 0, state goes to IDLE.
  - With TURN_CYCLES=1: release sampled at edge k, gnt low after k, IDLE after k+1, earliest new gnt after k+2.
- Fairness:
  - ptr advances only on release or revoke, never on an idle cycle.
  - A requester that held the grant ranks lowest on the next scan.
- Simultaneous events:
  - The owner drops req in the same cycle another child raises req: GAP is always honoured first.
  - arb_en falling during GRANT or GAP does not affect the current owner or the gap countdown; it blocks only the IDLE->GRANT transition.
- Invariants:
  - gnt is zero or one-hot at all times.
  - gnt_valid==|gnt.
  - gnt_id==index of the set gnt bit whenever gnt_valid=1.
- Out-of-range parameters: caught by an elaboration-time check (fatal).

Optional Feature:
- Macro: SUBTREE_SCHED_TIMEOUT_EN.
- Defined:
  - In GRANT, at the edge where hold_cnt==MAX_HOLD and req[gnt_id] is still 1, the grant is revoked exactly like a release.
  - Revoke effects: ptr advances, GAP entered, timeout=1 for that one cycle.
  - The revoked child may re-win later; it has lowest priority on the next scan.
- Undefined:
  - No revoke logic; hold is unlimited.
  - timeout tied to 0; hold_cnt still counts and saturates.

Test Plan:
- Reset with req=10'h3FF, arb_en=1, then release reset -> gnt=10'h001, gnt_id=0 one cycle after the first edge.
- Owner 0 drops req, all others keep req high, TURN_CYCLES=1 -> gnt=0 for exactly 2 cycles, then gnt=10'h002.
- Fairness: all 10 requesters held high and each releases after 3 cycles of grant -> grant order 0,1,...,9,0 with no repeats.
- Wrap: ptr=9, req=10'h201 -> grant to 9. After 9 releases with req[0] still high -> grant to 0.
- arb_en=0 with req=10'h010 -> gnt stays 0 indefinitely; set arb_en=1 -> gnt=10'h010 one cycle later. Drop arb_en during that grant -> grant is held.
- With SUBTREE_SCHED_TIMEOUT_EN, MAX_HOLD=64, req[3] stuck high -> gnt[3] revoked after 64 cycles of grant, timeout pulses 1 cycle, ptr=4. Without the macro -> gnt[3] held for 1000 cycles and hold_cnt saturates at 255. Assert rst_n mid-grant -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/subtree_rr_scheduler.sv
// Round-robin scheduler for one shared resource among the sibling children of a hierarchy node.
// Optional forced revoke of long grants is enabled by defining SUBTREE_SCHED_TIMEOUT_EN.
module subtree_rr_scheduler #(
  parameter int NUM_REQ     = 10,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 64,
  parameter int HOLD_W      = 8,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_id,
  output logic [HOLD_W-1:0]  hold_cnt,
  output logic               timeout,
  output logic [1:0]         dbg_state
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TURN_CYCLES < 1 || TURN_CYCLES > 15 ||
      HOLD_W < 1 || HOLD_W > 30 || (1 << HOLD_W) <= MAX_HOLD) begin : g_param_check
    $fatal(1, "subtree_rr_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  // Handshake: a child holds req[i] high for as long as it needs the resource and
  // owns it while gnt[i] is high; dropping req[i] is the release, seen one edge later.
  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [3:0]          gap_q, gap_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                timeout_q, timeout_d;
  logic                found;
  logic [IDW-1:0]      pick;
  logic                revoke;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

`ifdef SUBTREE_SCHED_TIMEOUT_EN
  assign revoke = req[id_q] && (hold_q == HOLD_W'(MAX_HOLD));
`else
  assign revoke = 1'b0;
`endif

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && req[wrap_add(ptr_q, off)]) begin
        found = 1'b1;
        pick  = wrap_add(ptr_q, off);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gap_d     = gap_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_en && found) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          id_d        = pick;
          hold_d      = HOLD_W'(1);
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!req[id_q] || revoke) begin
          // Release and revoke share one path so the old owner ranks lowest next scan.
          gnt_d     = '0;
          hold_d    = '0;
          ptr_d     = wrap_add(id_q, 1);
          gap_d     = 4'(TURN_CYCLES);
          timeout_d = revoke;
          state_d   = GAP;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) begin
          gap_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gap_q     <= '0;
      gnt_q     <= '0;
      id_q      <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = id_q;
  assign hold_cnt  = hold_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_subtree_rr_scheduler.sv
// Directed bench for subtree_rr_scheduler (NUM_REQ=10, TURN_CYCLES=1, HOLD_W=8).
// The revoke scenario follows SUBTREE_SCHED_TIMEOUT_EN when the bench is built with it.
module tb_subtree_rr_scheduler;

  localparam int NUM_REQ = 10;
  localparam int IDW     = 4;
  localparam int HOLD_W  = 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic               clk;
  logic               rst_n;
  logic               arb_en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [IDW-1:0]     gnt_id;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               timeout;
  logic [1:0]         dbg_state;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  subtree_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .TURN_CYCLES(1), .MAX_HOLD(64), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .hold_cnt(hold_cnt), .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input logic [NUM_REQ-1:0] r, input logic en);
    @(negedge clk);
    rst_n  = 1'b0;
    req    = r;
    arb_en = en;
    tick(2);
    rst_n = 1'b1;
  endtask

  // scoreboard: the grant sequence expected by the fairness run
  task automatic sb_check_gnt(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(gnt), e);
    end
  endtask

  // invariants sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("inv_onehot", 32'($onehot0(gnt)), 32'd1);
      check_eq("inv_valid", 32'(gnt_valid), 32'(|gnt));
      if (gnt_valid) check_eq("inv_id", 32'(gnt), 32'(1) << gnt_id);
    end
  end

  initial begin
    logic seen_to;
    rst_n  = 1'b0;
    arb_en = 1'b0;
    req    = '0;

    // reset state, then first grant one cycle after the first edge
    do_reset(10'h3FF, 1'b1);
    rst_n = 1'b0;
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_valid", 32'(gnt_valid), 32'h0);
    check_eq("rst_id", 32'(gnt_id), 32'h0);
    check_eq("rst_hold", 32'(hold_cnt), 32'h0);
    check_eq("rst_timeout", 32'(timeout), 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    tick();
    check_eq("first_gnt", 32'(gnt), 32'h001);
    check_eq("first_id", 32'(gnt_id), 32'h0);
    check_eq("first_hold", 32'(hold_cnt), 32'h1);

    // owner 0 releases while others wait: exactly two empty cycles, then child 1
    req = 10'h3FE;
    tick();
    check_eq("gap1_gnt", 32'(gnt), 32'h0);
    check_eq("gap1_state", 32'(dbg_state), 32'(S_GAP));
    check_eq("gap1_id_held", 32'(gnt_id), 32'h0);
    tick();
    check_eq("gap2_gnt", 32'(gnt), 32'h0);
    check_eq("gap2_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    check_eq("after_gap_gnt", 32'(gnt), 32'h002);

    // fairness: all high, each owner releases after 3 grant cycles -> 0..9,0
    for (int e = 0; e < NUM_REQ; e++) exp_q.push_back(32'(1) << e);
    exp_q.push_back(32'h001);
    do_reset(10'h3FF, 1'b1);
    tick();
    for (int g = 0; g < NUM_REQ; g++) begin
      sb_check_gnt("fair_gnt");
      tick(2);
      check_eq("fair_hold3", 32'(hold_cnt), 32'd3);
      req[g] = 1'b0;
      tick();
      check_eq("fair_rel", 32'(gnt), 32'h0);
      req[g] = 1'b1;
      tick(2);
    end
    sb_check_gnt("fair_wrap");

    // wrap: get ptr to 9 via child 8, then 9 wins over 0, then 0 after 9 releases
    do_reset(10'h100, 1'b1);
    tick();
    check_eq("wrap_own8", 32'(gnt), 32'h100);
    req = 10'h301;
    tick();
    req = 10'h201;
    tick(3);
    check_eq("wrap_gnt9", 32'(gnt), 32'h200);
    check_eq("wrap_id9", 32'(gnt_id), 32'd9);
    req = 10'h001;
    tick(3);
    check_eq("wrap_gnt0", 32'(gnt), 32'h001);

    // arb_en gating
    do_reset(10'h010, 1'b0);
    tick(6);
    check_eq("en0_gnt", 32'(gnt), 32'h0);
    check_eq("en0_state", 32'(dbg_state), 32'(S_IDLE));
    arb_en = 1'b1;
    tick();
    check_eq("en1_gnt", 32'(gnt), 32'h010);
    arb_en = 1'b0;
    tick(3);
    check_eq("en_drop_gnt", 32'(gnt), 32'h010);
    check_eq("en_drop_hold", 32'(hold_cnt), 32'd4);
    req = '0;
    tick();
    check_eq("en_drop_rel", 32'(dbg_state), 32'(S_GAP));
    tick();
    check_eq("en_drop_gapdone", 32'(dbg_state), 32'(S_IDLE));
    req = 10'h010;
    tick(2);
    check_eq("en_drop_nogrant", 32'(gnt), 32'h0);

    // stuck requester 3
    do_reset(10'h008, 1'b1);
    tick();
    check_eq("stuck_gnt", 32'(gnt), 32'h008);
`ifdef SUBTREE_SCHED_TIMEOUT_EN
    tick(63);
    check_eq("to_hold64", 32'(hold_cnt), 32'd64);
    check_eq("to_pre_gnt", 32'(gnt), 32'h008);
    check_eq("to_pre_pulse", 32'(timeout), 32'd0);
    req = 10'h018;
    tick();
    check_eq("to_revoked", 32'(gnt), 32'h0);
    check_eq("to_pulse", 32'(timeout), 32'd1);
    tick();
    check_eq("to_pulse_end", 32'(timeout), 32'd0);
    tick();
    check_eq("to_ptr4", 32'(gnt), 32'h010);
    req = 10'h008;
`else
    seen_to = 1'b0;
    for (int i = 1; i < 1000; i++) begin
      tick();
      seen_to = seen_to | timeout;
      if (i == 254) check_eq("hold_255", 32'(hold_cnt), 32'd255);
    end
    check_eq("hold_1000_gnt", 32'(gnt), 32'h008);
    check_eq("hold_sat", 32'(hold_cnt), 32'd255);
    check_eq("hold_no_timeout", 32'(seen_to), 32'd0);
    check_eq("hold_id3", 32'(gnt_id), 32'd3);
`endif

    // async reset mid-grant clears outputs before the next edge
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_gnt", 32'(gnt), 32'h0);
    check_eq("arst_valid", 32'(gnt_valid), 32'h0);
    check_eq("arst_id", 32'(gnt_id), 32'h0);
    check_eq("arst_hold", 32'(hold_cnt), 32'h0);
    check_eq("arst_state", 32'(dbg_state), 32'(S_IDLE));
    #1;
    rst_n = 1'b1;
    req   = '0;
    tick(2);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
